uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin packet arbiter that shares the single transmit path of the `uart` top between `NREQ` requesters. It sits in front of the UART `tx_set`/`din_tx` write port. It grants one requester at a time and holds the grant for a whole packet, which ends on the `last` byte. It meters bytes into the UART using the transmit-buffer ready indication.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `HDR_TAG`, default 4'hA: upper nibble of the optional packet header byte.

Ports:
- `clock`, input, 1: single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, NREQ: per-requester "byte valid / packet in progress".
- `last`, input, NREQ: per-requester "current byte is last of packet".
- `data`, input, 8*NREQ: per-requester byte. Requester i drives `data[8*i+7:8*i]`.
- `ack`, output, NREQ: one-cycle pulse meaning requester i's byte was taken at the previous edge.
- `grant`, output, NREQ: one-hot current owner, all zero when idle.
- `busy`, output, 1: high whenever the FSM is not IDLE.
- `tx_ready`, input, 1: UART transmit buffer can accept a byte.
- `tx_set`, output, 1: one-cycle write strobe to the UART transmit buffer.
- `din_tx`, output, 8: byte written with `tx_set`.

## Operation

States: IDLE, HDR, XFER, WAIT.

- **IDLE**: if any `req` bit is set, choose the winner as the first set bit searching upward (with wrap) from `ptr+1`.
  - Load `grant` and set `ptr` to the winner.
  - Go to HDR if the header is compiled in, otherwise go to XFER.
- **HDR**: when `tx_ready`=1, issue the header byte `{HDR_TAG, 1'b0, id[2:0]}` with `tx_set`, then go to WAIT. No `ack` is issued for the header.
- **XFER**:
  - If `req[g]`=0, where g is the owner, abandon the packet: clear `grant` and go to IDLE. Nothing is sent.
  - Else if `tx_ready`=1, issue `data[g]` with `tx_set` and `ack[g]`.
    - If `last[g]`=1, the next state is WAIT with the release flag set.
    - Otherwise the next state is WAIT.
  - Else (`tx_ready`=0), stay in XFER.
- **WAIT**: lasts exactly one cycle so the `tx_ready` update from the UART buffer can land.
  - If the release flag is set, go to IDLE and clear `grant`.
  - Otherwise go to XFER, or return to XFER after a header.
- Requests from non-owners are ignored until the owner releases. A new arbitration happens only in IDLE.
- `ptr` advances only on a grant. This guarantees no starvation: with all requesters active, packets are served in order 0,1,2,3,0,...

Reset values (asserted asynchronously):
- state = IDLE
- `ptr` = NREQ-1, so requester 0 has first priority
- `grant` = 0, `ack` = 0, `tx_set` = 0, `din_tx` = 8'h00, `busy` = 0

A reset in the middle of a packet drops it immediately. No partial `tx_set` is produced.

## Timing

- All outputs are registered.
- The decision is made on the edge E where the state is XFER/HDR and the conditions hold. `tx_set`, `din_tx` and `ack` are high during the cycle after E.
- The requester must present its next byte (or drop `req`) by edge E+2. The FSM samples `data`/`req` no earlier than E+2, because WAIT occupies E+1.
- Maximum throughput is one byte per 2 cycles. Each `tx_set` is followed by at least one cycle of `tx_set`=0.
- Arbitration latency: a `req` rising in IDLE produces `grant` on the next edge.
  - The first `tx_set` follows at the earliest one edge later (XFER with `tx_ready`=1).
  - With the header compiled in, the header goes first and the first data byte follows at the earliest 2 edges after the header.
- Simultaneous `last` and `req` drop cannot occur in the same cycle by protocol. If `req[g]`=0 in XFER, `last[g]` is ignored.
- `tx_ready`=0 indefinitely keeps the FSM in XFER/HDR with the grant held.

## Configuration

- `UART_ARB_HEADER_EN` defined: the HDR state is compiled in. Every packet is prefixed by `{HDR_TAG, 1'b0, id}`.
- Not defined: HDR is absent. IDLE goes directly to XFER and only requester bytes reach the UART.
- `ptr`/`grant` behaviour is identical in both builds.

## Test plan

- **Reset mid-packet**: drive `reset`=0 while in XFER with `tx_ready`=1. Required: `tx_set`, `ack` and `grant` go to 0 immediately. After release, `req`=4'b1111 grants requester 0 first.
- **Round robin**: hold `req`=4'b1111 with every byte marked `last`, `tx_ready`=1. Required: `grant` sequence 0001, 0010, 0100, 1000, 0001, and `din_tx` equals each requester's byte in turn.
- **Packet lock**: requester 2 sends 3 bytes 8'h11, 8'h22, 8'h33 with `last` on 8'h33, while `req[0]` is held high. Required: three `tx_set` pulses carrying 8'h11, 8'h22, 8'h33 with `grant`=0100 throughout, then requester 0 is granted.
- **Backpressure**: `tx_ready`=0 for 20 cycles during XFER. Required: no `tx_set` and `grant` held. `tx_set` rises one edge after `tx_ready` returns to 1.
- **Abort**: requester 1 drops `req` after 1 byte without `last`. Required: `grant` is cleared and `busy`=0 one edge after the drop, with no extra `tx_set`.
- **Header build** (`UART_ARB_HEADER_EN`): requester 3 sends a single byte 8'h5C. Required: `din_tx` sequence 8'hA3 then 8'h5C, and only one `ack[3]` pulse.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side (req/last/data/ack/grant/busy) and the UART
// transmit write port (tx_ready/tx_set/din_tx) of the round-robin arbiter.
//   slave  : arbiter view (samples requests and tx_ready, drives the rest)
//   master : environment view (requesters + UART buffer)
// Parameter NREQ must match the arbiter instance it is connected to.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;       // byte valid / packet in progress
  logic [NREQ-1:0]   last;      // current byte is last of packet
  logic [8*NREQ-1:0] data;      // requester i owns data[8*i+7:8*i]
  logic [NREQ-1:0]   ack;       // byte of requester i taken at previous edge
  logic [NREQ-1:0]   grant;     // one-hot owner, zero when idle
  logic              busy;      // arbiter not idle
  logic              tx_ready;  // UART transmit buffer can accept a byte
  logic              tx_set;    // write strobe to UART transmit buffer
  logic [7:0]        din_tx;    // byte written with tx_set

  modport master (
    output req, last, data, tx_ready,
    input  ack, grant, busy, tx_set, din_tx
  );

  modport slave (
    input  req, last, data, tx_ready,
    output ack, grant, busy, tx_set, din_tx
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin packet arbiter sharing the single UART transmit write port
// between NREQ requesters. A grant is held for a whole packet (ending on the
// requester's last byte) and bytes are metered into the UART using tx_ready,
// at most one byte every two cycles.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : uart_tx_arbiter_if.slave (req/last/data in, ack/grant/busy out,
//            tx_ready in, tx_set/din_tx out); all outputs are registered
//
// Build option:
//   UART_ARB_HEADER_EN - when defined, every packet is prefixed by the header
//                        byte {HDR_TAG, 1'b0, id[2:0]} (no ack for it).
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         NREQ    = 4,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef UART_ARB_HEADER_EN
    S_HDR  = 2'd1,
`endif
    S_XFER = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;          // last granted requester (= owner while busy)
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_set_q, tx_set_d;
  logic [7:0]      din_tx_q, din_tx_d;
  logic            busy_q, busy_d;
  logic            rel_q, rel_d;          // release after the WAIT cycle

  logic            win_found_s;
  logic [2:0]      win_idx_s;
  logic [NREQ-1:0] win_onehot_s;
  logic [3:0]      cand_s;
  logic            own_req_s;
  logic            own_last_s;
  logic [7:0]      own_data_s;

  // Winner search: first set req bit upward from ptr+1 with wrap. The loop
  // runs from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    win_found_s  = 1'b0;
    win_idx_s    = ptr_q;
    win_onehot_s = '0;
    cand_s       = 4'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = {1'b0, ptr_q} + 4'(k);
      if (cand_s >= 4'(NREQ)) begin
        cand_s = cand_s - 4'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      for (int i = 0; i < NREQ; i++) begin
        if ((4'(i) == cand_s) && bus.req[i]) begin
          win_found_s = 1'b1;
          win_idx_s   = cand_s[2:0];
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      win_onehot_s[i] = (3'(i) == win_idx_s);
    end
  end

  // Owner view: select the current owner's req/last/data by ptr.
  always_comb begin
    own_req_s  = 1'b0;
    own_last_s = 1'b0;
    own_data_s = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == ptr_q) begin
        own_req_s  = bus.req[i];
        own_last_s = bus.last[i];
        own_data_s = bus.data[8*i +: 8];
      end else begin
        own_req_s = own_req_s;
      end
    end
  end

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    ack_d    = '0;
    tx_set_d = 1'b0;
    din_tx_d = din_tx_q;
    rel_d    = rel_q;
    case (state_q)
      S_IDLE: begin
        rel_d = 1'b0;
        if (win_found_s) begin
          grant_d = win_onehot_s;
          ptr_d   = win_idx_s;
`ifdef UART_ARB_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_XFER;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef UART_ARB_HEADER_EN
      S_HDR: begin
        if (bus.tx_ready) begin
          tx_set_d = 1'b1;
          din_tx_d = {HDR_TAG, 1'b0, ptr_q};
          state_d  = S_WAIT;
        end else begin
          state_d = S_HDR;
        end
      end
`endif
      S_XFER: begin
        // A dropped req abandons the packet; last is ignored in that case.
        if (!own_req_s) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (bus.tx_ready) begin
          tx_set_d = 1'b1;
          din_tx_d = own_data_s;
          ack_d    = grant_q;
          rel_d    = own_last_s;
          state_d  = S_WAIT;
        end else begin
          state_d = S_XFER;
        end
      end
      S_WAIT: begin
        // One idle cycle so the UART's tx_ready update is visible next.
        if (rel_q) begin
          grant_d = '0;
          rel_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_XFER;
        end
      end
      default: begin
        grant_d = '0;
        rel_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 3'(NREQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      tx_set_q <= 1'b0;
      din_tx_q <= 8'h00;
      busy_q   <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      tx_set_q <= tx_set_d;
      din_tx_q <= din_tx_d;
      busy_q   <= busy_d;
      rel_q    <= rel_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.ack    = ack_q;
  assign bus.tx_set = tx_set_q;
  assign bus.din_tx = din_tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NREQ=4). Expected UART writes (byte and
// accompanying ack) are queued as stimulus is set up and popped by a monitor
// on every tx_set. Header bytes are queued only when UART_ARB_HEADER_EN is set.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) bus_if ();

  uart_tx_arbiter #(.NREQ(4), .HDR_TAG(4'hA)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [7:0] byte_v;
    logic [3:0] ack_v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [3:0] a);
    exp_t e;
    e.byte_v = b;
    e.ack_v  = a;
    sb.push_back(e);
  endtask

  task automatic push_hdr(input int id);
`ifdef UART_ARB_HEADER_EN
    push_byte({4'hA, 1'b0, 3'(id)}, 4'h0);
`else
    if (id < 0) $display("bad requester id %0d", id);
`endif
  endtask

  task automatic set_byte(input int id, input logic [7:0] b, input logic l);
    bus_if.data[8*id +: 8] = b;
    bus_if.last[id]        = l;
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (bus_if.grant != 4'h0) hit = 1'b1;
    end
    check(tag, 32'(bus_if.grant), 32'(exp));
  endtask

  task automatic wait_ack(input logic [3:0] m, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if ((bus_if.ack & m) != 4'h0) hit = 1'b1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (bus_if.grant == 4'h0) hit = 1'b1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  // Scoreboard monitor: each tx_set must match the next queued byte/ack,
  // and ack must stay low on cycles without a write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_if.tx_set === 1'b1) begin
        if (sb.size() == 0) begin
          check("tx_set_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("din_tx", 32'(bus_if.din_tx), 32'(mon_e.byte_v));
          check("ack_with_tx", 32'(bus_if.ack), 32'(mon_e.ack_v));
        end
      end else begin
        check("ack_without_tx", 32'(bus_if.ack), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.req      = 4'h0;
    bus_if.last     = 4'h0;
    bus_if.data     = 32'h0;
    bus_if.tx_ready = 1'b0;
    rst_n           = 1'b0;
    step(3);

    // Reset state
    check("rst_grant",  32'(bus_if.grant),  32'd0);
    check("rst_busy",   32'(bus_if.busy),   32'd0);
    check("rst_tx_set", 32'(bus_if.tx_set), 32'd0);
    check("rst_din_tx", 32'(bus_if.din_tx), 32'd0);
    check("rst_ack",    32'(bus_if.ack),    32'd0);
    rst_n = 1'b1;
    step(2);

    // Round robin: all requesting, every byte last
    bus_if.tx_ready = 1'b1;
    for (int id = 0; id < 4; id++) set_byte(id, {4'(id + 1), 4'(id)}, 1'b1);
    for (int k = 0; k < 5; k++) begin
      push_hdr(k % 4);
      push_byte({4'((k % 4) + 1), 4'(k % 4)}, 4'(1 << (k % 4)));
    end
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(4'(1 << (k % 4)), "rr_grant");
      wait_idle("rr_release");
    end
    bus_if.req = 4'b0000;
    step(2);
    check("rr_drained", 32'(sb.size()), 32'd0);
    check("rr_busy_low", 32'(bus_if.busy), 32'd0);

    // Packet lock: requester 2 sends three bytes while requester 0 waits
    set_byte(0, 8'h77, 1'b1);
    set_byte(2, 8'h11, 1'b0);
    push_hdr(2);
    push_byte(8'h11, 4'b0100);
    push_byte(8'h22, 4'b0100);
    push_byte(8'h33, 4'b0100);
    push_hdr(0);
    push_byte(8'h77, 4'b0001);
    bus_if.req = 4'b0101;
    wait_grant(4'b0100, "lock_grant");
    wait_ack(4'b0100, "lock_ack_11");
    check("lock_hold_1", 32'(bus_if.grant), 32'b0100);
    set_byte(2, 8'h22, 1'b0);
    wait_ack(4'b0100, "lock_ack_22");
    check("lock_hold_2", 32'(bus_if.grant), 32'b0100);
    set_byte(2, 8'h33, 1'b1);
    wait_ack(4'b0100, "lock_ack_33");
    check("lock_hold_3", 32'(bus_if.grant), 32'b0100);
    bus_if.req[2]  = 1'b0;
    bus_if.last[2] = 1'b0;
    wait_grant(4'b0001, "lock_next_grant");
    wait_idle("lock_release");
    bus_if.req = 4'b0000;
    step(2);

    // Backpressure: tx_ready low for 20 cycles with requester 1 granted
    bus_if.tx_ready = 1'b0;
    set_byte(1, 8'h9B, 1'b1);
    push_hdr(1);
    push_byte(8'h9B, 4'b0010);
    bus_if.req = 4'b0010;
    wait_grant(4'b0010, "bp_grant");
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("bp_no_tx", 32'(bus_if.tx_set), 32'd0);
      check("bp_hold",  32'(bus_if.grant),  32'b0010);
    end
    bus_if.tx_ready = 1'b1;
    step(1);
    check("bp_resume", 32'(bus_if.tx_set), 32'd1);
    wait_idle("bp_release");
    bus_if.req = 4'b0000;
    step(2);

    // Abort: requester 1 drops req after one byte without last
    set_byte(1, 8'h44, 1'b0);
    push_hdr(1);
    push_byte(8'h44, 4'b0010);
    bus_if.req = 4'b0010;
    wait_grant(4'b0010, "abort_grant");
    wait_ack(4'b0010, "abort_ack");
    step(1);
    bus_if.req = 4'b0000;
    step(1);
    check("abort_grant_clr", 32'(bus_if.grant), 32'd0);
    check("abort_busy_low",  32'(bus_if.busy),  32'd0);
    step(3);
    check("abort_no_extra", 32'(sb.size()), 32'd0);

    // Reset mid-packet while a byte is being written
    set_byte(3, 8'hE7, 1'b0);
    push_hdr(3);
    push_byte(8'hE7, 4'b1000);
    bus_if.req = 4'b1000;
    wait_grant(4'b1000, "mid_grant");
    wait_ack(4'b1000, "mid_ack");
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_tx_set", 32'(bus_if.tx_set), 32'd0);
    check("mid_ack_clr", 32'(bus_if.ack),   32'd0);
    check("mid_grant",  32'(bus_if.grant),  32'd0);
    check("mid_busy",   32'(bus_if.busy),   32'd0);
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(1);
    bus_if.last = 4'b1111;
    push_hdr(0);
    push_byte(8'h77, 4'b0001);
    bus_if.req = 4'b1111;
    wait_grant(4'b0001, "post_reset_grant");
    wait_idle("post_reset_release");
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    step(2);

`ifdef UART_ARB_HEADER_EN
    // Header build: requester 3 single byte, header A3 precedes 5C
    set_byte(3, 8'h5C, 1'b1);
    push_byte(8'hA3, 4'b0000);
    push_byte(8'h5C, 4'b1000);
    bus_if.req = 4'b1000;
    wait_grant(4'b1000, "hdr_grant");
    wait_idle("hdr_release");
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    step(3);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
